// File: rtl/crc32_frame_check_if.sv
// Byte-stream and frame-result signals of the CRC-32 frame checker.
// The checker takes the slave side; the upstream/downstream logic takes the master side.
interface crc32_frame_check_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             res_valid;
    logic             res_ready;
    logic             res_ok;
    logic             res_runt;
    logic             res_ovf;
    logic [CNT_W-1:0] res_len;
    logic [31:0]      res_crc;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] bad_cnt;

    modport master (
        output in_data, in_valid, in_last, res_ready,
        input  in_ready, res_valid, res_ok, res_runt, res_ovf, res_len, res_crc,
               good_cnt, bad_cnt
    );

    modport slave (
        input  in_data, in_valid, in_last, res_ready,
        output in_ready, res_valid, res_ok, res_runt, res_ovf, res_len, res_crc,
               good_cnt, bad_cnt
    );
endinterface

// File: rtl/crc32_frame_check.sv
// Receive-side CRC-32 (poly 0x04C11DB7, MSB-first, init all-ones, no final XOR) frame checker.
// Payload + FCS leaves a zero residue; result is held until downstream takes it.
module crc32_frame_check #(
    parameter int CNT_W   = 16,
    parameter int MIN_LEN = 5
) (
    input logic                clk,
    input logic                rst,
    crc32_frame_check_if.slave bus
);
    localparam logic [31:0] POLY     = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {IDLE, DATA, RESULT} state_t;

    state_t           state, state_nxt;
    logic [31:0]      crc, crc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf, ovf_nxt;
    logic [CNT_W-1:0] good_cnt, bad_cnt;
    logic             in_result, fire, done, runt, ok;
    logic [31:0]      crc_step;

    // One table entry: the byte placed in the top of the register, shifted through 8 steps.
    function automatic logic [31:0] crc_tab(input logic [7:0] idx);
        logic [31:0] r;
        r = {idx, 24'h0};
        for (int i = 0; i < 8; i++)
            r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        return r;
    endfunction

    assign in_result = (state == RESULT);
    assign fire      = bus.in_valid && !in_result;
    assign done      = in_result && bus.res_ready;
    assign crc_step  = {crc[23:0], 8'h00} ^ crc_tab(crc[31:24] ^ bus.in_data);
    assign runt      = in_result && (cnt < CNT_W'(MIN_LEN));
    assign ok        = in_result && (crc == 32'h0) && !runt && !ovf;

    always_comb begin
        state_nxt = state;
        crc_nxt   = crc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        case (state)
            IDLE, DATA: begin
                if (fire) begin
                    crc_nxt   = crc_step;
                    cnt_nxt   = (&cnt) ? cnt : cnt + 1'b1;
                    ovf_nxt   = ovf | (&cnt);
                    state_nxt = bus.in_last ? RESULT : DATA;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                    crc_nxt   = CRC_INIT;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            crc   <= CRC_INIT;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            crc   <= crc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Statistics advance once per frame, on the result handshake, and stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (done) begin
            if (ok) begin
                if (!(&good_cnt)) good_cnt <= good_cnt + 1'b1;
            end else if (!(&bad_cnt)) begin
                bad_cnt <= bad_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = !in_result;
    assign bus.res_valid = in_result;
    assign bus.res_ok    = ok;
    assign bus.res_runt  = runt;
    assign bus.res_ovf   = in_result && ovf;
    assign bus.res_len   = (cnt > CNT_W'(3)) ? cnt - CNT_W'(4) : '0;
    assign bus.res_crc   = crc;
    assign bus.good_cnt  = good_cnt;
    assign bus.bad_cnt   = bad_cnt;
endmodule

// File: tb/tb_crc32_frame_check.sv
// Bench for crc32_frame_check: a wide (CNT_W=16) and a narrow (CNT_W=4) checker see the
// same byte stream and are compared against a bit-serial CRC/length model of each frame.
module tb_crc32_frame_check;
    localparam int          MIN_LEN = 5;
    localparam logic [31:0] POLY    = 32'h04C11DB7;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic        ok;
        logic        runt;
        logic        ovf;
        int          len;
        logic [31:0] crc;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] drv_data   = 8'h00;
    logic       drv_valid  = 1'b0;
    logic       drv_last   = 1'b0;
    logic       drv_rready = 1'b1;

    always #5 clk = ~clk;

    crc32_frame_check_if #(.CNT_W(16)) b16 ();
    crc32_frame_check_if #(.CNT_W(4))  b4 ();

    assign b16.in_data   = drv_data;
    assign b16.in_valid  = drv_valid;
    assign b16.in_last   = drv_last;
    assign b16.res_ready = drv_rready;
    assign b4.in_data    = drv_data;
    assign b4.in_valid   = drv_valid;
    assign b4.in_last    = drv_last;
    assign b4.res_ready  = drv_rready;

    crc32_frame_check #(.CNT_W(16), .MIN_LEN(MIN_LEN)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    crc32_frame_check #(.CNT_W(4),  .MIN_LEN(MIN_LEN)) dut4  (.clk(clk), .rst(rst), .bus(b4));

    int   vectors = 0, miscompares = 0;
    bq_t  frm, nxt;
    res_t e16, e4;
    int   exp_g16 = 0, exp_b16 = 0, exp_g4 = 0, exp_b4 = 0;
    logic [7:0] known [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                               8'h38, 8'h39, 8'h03, 8'h76, 8'hE6, 8'hE7};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Long division, one message bit at a time.
    function automatic logic [31:0] crc_of(input bq_t q);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i])
            for (int b = 7; b >= 0; b--)
                c = (c[31] ^ q[i][b]) ? ((c << 1) ^ POLY) : (c << 1);
        return c;
    endfunction

    function automatic res_t model(input bq_t q, input int w);
        res_t r;
        int   sat, n, cnt;
        sat    = (1 << w) - 1;
        n      = q.size();
        cnt    = (n > sat) ? sat : n;
        r.crc  = crc_of(q);
        r.ovf  = (n > sat);
        r.runt = (cnt < MIN_LEN);
        r.len  = (cnt >= 4) ? cnt - 4 : 0;
        r.ok   = (r.crc == 32'h0) && !r.runt && !r.ovf;
        return r;
    endfunction

    function automatic int sat_inc(input int v, input int w);
        return (v == (1 << w) - 1) ? v : v + 1;
    endfunction

    function automatic bq_t make_good(input int p);
        bq_t         q;
        logic [31:0] f;
        for (int i = 0; i < p; i++) q.push_back(8'($urandom));
        f = crc_of(q);
        q.push_back(f[31:24]);
        q.push_back(f[23:16]);
        q.push_back(f[15:8]);
        q.push_back(f[7:0]);
        return q;
    endfunction

    function automatic void corrupt();
        int k;
        k = $urandom_range(frm.size() - 1, 0);
        frm[k] = frm[k] ^ (8'h01 << $urandom_range(7, 0));
    endfunction

    // Called on a falling edge; returns on the falling edge after the byte was taken.
    task automatic put_byte(input logic [7:0] b, input logic l);
        int k = 0;
        drv_data  = b;
        drv_last  = l;
        drv_valid = 1'b1;
        while (!b16.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k == 100) chk("in_ready_timeout", {63'h0, b16.in_ready}, 64'h1);
        @(negedge clk);
        drv_valid = 1'b0;
        drv_last  = 1'b0;
    endtask

    task automatic send_frame(input int gap_max);
        for (int i = 0; i < frm.size(); i++) begin
            repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            put_byte(frm[i], i == frm.size() - 1);
        end
    endtask

    task automatic chk_res(input string tag, input logic v, input logic ok, input logic runt,
                           input logic ovf, input logic [15:0] len, input logic [31:0] crc,
                           input res_t e);
        chk({tag, ".valid"}, {63'h0, v}, 64'h1);
        chk({tag, ".ok"},    {63'h0, ok}, {63'h0, e.ok});
        chk({tag, ".runt"},  {63'h0, runt}, {63'h0, e.runt});
        chk({tag, ".ovf"},   {63'h0, ovf}, {63'h0, e.ovf});
        chk({tag, ".len"},   {48'h0, len}, 64'(e.len));
        chk({tag, ".crc"},   {32'h0, crc}, {32'h0, e.crc});
    endtask

    task automatic check_result(input string tag);
        e16 = model(frm, 16);
        e4  = model(frm, 4);
        chk_res({tag, "/w16"}, b16.res_valid, b16.res_ok, b16.res_runt, b16.res_ovf,
                b16.res_len, b16.res_crc, e16);
        chk_res({tag, "/w4"}, b4.res_valid, b4.res_ok, b4.res_runt, b4.res_ovf,
                {12'h0, b4.res_len}, b4.res_crc, e4);
    endtask

    task automatic handshake(input string tag);
        drv_rready = 1'b1;
        @(negedge clk);
        if (e16.ok) exp_g16 = sat_inc(exp_g16, 16); else exp_b16 = sat_inc(exp_b16, 16);
        if (e4.ok)  exp_g4  = sat_inc(exp_g4, 4);   else exp_b4  = sat_inc(exp_b4, 4);
        chk({tag, ".valid_drop"}, {63'h0, b16.res_valid}, 64'h0);
        chk({tag, ".ready_back"}, {63'h0, b16.in_ready}, 64'h1);
        chk({tag, ".good16"}, {48'h0, b16.good_cnt}, 64'(exp_g16));
        chk({tag, ".bad16"},  {48'h0, b16.bad_cnt},  64'(exp_b16));
        chk({tag, ".good4"},  {60'h0, b4.good_cnt},  64'(exp_g4));
        chk({tag, ".bad4"},   {60'h0, b4.bad_cnt},   64'(exp_b4));
    endtask

    task automatic load_known();
        frm.delete();
        foreach (known[i]) frm.push_back(known[i]);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"}, {63'h0, b16.in_ready}, 64'h1);
        chk({tag, ".res_valid"}, {63'h0, b16.res_valid}, 64'h0);
        chk({tag, ".res_ok"}, {63'h0, b16.res_ok}, 64'h0);
        chk({tag, ".res_runt"}, {63'h0, b16.res_runt}, 64'h0);
        chk({tag, ".res_ovf"}, {63'h0, b16.res_ovf}, 64'h0);
        chk({tag, ".res_len"}, {48'h0, b16.res_len}, 64'h0);
        chk({tag, ".res_crc"}, {32'h0, b16.res_crc}, 64'hFFFF_FFFF);
        chk({tag, ".good16"}, {48'h0, b16.good_cnt}, 64'h0);
        chk({tag, ".bad16"}, {48'h0, b16.bad_cnt}, 64'h0);
        chk({tag, ".good4"}, {60'h0, b4.good_cnt}, 64'h0);
        chk({tag, ".bad4"}, {60'h0, b4.bad_cnt}, 64'h0);
        chk({tag, ".ready4"}, {63'h0, b4.in_ready}, 64'h1);
    endtask

    initial begin
        // reset
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post_reset");

        // reference frame "123456789" + FCS 0376E6E7
        load_known();
        send_frame(0);
        check_result("good");
        chk("good.crc_zero", {32'h0, b16.res_crc}, 64'h0);
        chk("good.len9", {48'h0, b16.res_len}, 64'd9);
        chk("good.ok", {63'h0, b16.res_ok}, 64'h1);
        handshake("good");

        // corrupted last FCS byte
        load_known();
        frm[12] = 8'hE6;
        send_frame(0);
        check_result("bad_fcs");
        chk("bad_fcs.ok", {63'h0, b16.res_ok}, 64'h0);
        handshake("bad_fcs");

        // runts
        frm = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_frame(0);
        check_result("runt4");
        chk("runt4.runt", {63'h0, b16.res_runt}, 64'h1);
        handshake("runt4");
        frm = '{8'hA5};
        send_frame(0);
        check_result("runt1");
        handshake("runt1");

        // result held under backpressure while the next frame's first byte waits
        frm = make_good(8);
        nxt = make_good(6);
        drv_rready = 1'b0;
        send_frame(0);
        check_result("bp");
        drv_data  = nxt[0];
        drv_last  = 1'b0;
        drv_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp.in_ready_low", {63'h0, b16.in_ready}, 64'h0);
            chk("bp.valid_held", {63'h0, b16.res_valid}, 64'h1);
            chk("bp.crc_held", {32'h0, b16.res_crc}, {32'h0, e16.crc});
            chk("bp.len_held", {48'h0, b16.res_len}, 64'(e16.len));
        end
        handshake("bp");
        frm = nxt;
        send_frame(0);
        check_result("bp_next");
        handshake("bp_next");

        // good, bad, good with random valid gaps
        for (int j = 0; j < 3; j++) begin
            frm = make_good($urandom_range(12, 1));
            if (j == 1) corrupt();
            send_frame(3);
            check_result("b2b");
            chk("b2b.ok_pattern", {63'h0, b16.res_ok}, (j == 1) ? 64'h0 : 64'h1);
            handshake("b2b");
        end

        // random lengths, including some past the narrow counter's range
        for (int j = 0; j < 4; j++) begin
            frm = make_good(($urandom_range(1, 0) == 1) ? $urandom_range(10, 0)
                                                        : $urandom_range(26, 12));
            if ($urandom_range(1, 0) == 1) corrupt();
            send_frame(2);
            check_result("rnd");
            handshake("rnd");
        end

        // reset in the middle of a frame
        frm = make_good(8);
        for (int i = 0; i < 5; i++) put_byte(frm[i], 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk_idle("mid_reset");
        rst = 1'b0;
        exp_g16 = 0; exp_b16 = 0; exp_g4 = 0; exp_b4 = 0;
        load_known();
        send_frame(1);
        check_result("after_reset");
        handshake("after_reset");
        chk("after_reset.good1", {48'h0, b16.good_cnt}, 64'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_reset.single_valid", {63'h0, b16.res_valid}, 64'h0);
        end

        // 20-byte good frame: narrow counter saturates
        frm = make_good(16);
        send_frame(0);
        check_result("ovf20");
        chk("ovf20.ovf4", {63'h0, b4.res_ovf}, 64'h1);
        chk("ovf20.ok4", {63'h0, b4.res_ok}, 64'h0);
        chk("ovf20.ok16", {63'h0, b16.res_ok}, 64'h1);
        handshake("ovf20");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
